// File: rtl/awgn_clt_multi.sv
// Multi-channel AWGN source: per channel, sums NUM_SUM LFSR uniforms, removes the mean, applies Q4.4 gain and saturates.
// Latency: first out_valid NUM_SUM+1 enabled edges after reset or seed_load; then one sample per NUM_SUM enabled cycles.
// Backpressure: out_valid/out_data hold while ~out_ready; accumulation stalls only when a finished sum cannot move forward.
module awgn_clt_multi #(
    parameter int          OUT_W   = 16,
    parameter int          NUM_CH  = 2,
    parameter int          NUM_SUM = 4,
    parameter logic [31:0] SEED    = 32'hACE1_2468
) (
    input  logic                    CLK_100MHZ,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    seed_load,
    input  logic [31:0]             seed,
    input  logic [7:0]              gain,
    output logic [NUM_CH*OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready
);
    localparam int LOG2_SUM = $clog2(NUM_SUM);
    localparam int ACC_W    = OUT_W + LOG2_SUM;
    localparam int CEN_W    = ACC_W + 1;
    localparam int PRD_W    = CEN_W + 9;

    localparam logic [31:0] TAPS   = 32'h8020_0003;
    localparam logic [31:0] GOLDEN = 32'h9E37_79B9;

    // Mean of a sum of NUM_SUM uniforms: NUM_SUM * 2^(OUT_W-1) = 2^(ACC_W-1)
    localparam logic signed [CEN_W-1:0] MEAN    = {2'b01, {(ACC_W-1){1'b0}}};
    localparam logic signed [PRD_W-1:0] SAT_MAX = {{(PRD_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PRD_W-1:0] SAT_MIN = {{(PRD_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    localparam logic [LOG2_SUM-1:0] CNT_LAST = LOG2_SUM'(NUM_SUM - 1);

    // Per-channel seed derivation; an all-zero Galois LFSR would lock up, so zero maps to 1
    function automatic logic [31:0] chan_seed(input logic [31:0] base, input int c);
        logic [31:0] s;
        s = base ^ (32'(c) * GOLDEN);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
    endfunction

    logic [31:0]                lfsr    [NUM_CH];
    logic [ACC_W-1:0]           acc     [NUM_CH];
    logic [ACC_W-1:0]           sum_r   [NUM_CH];
    logic [ACC_W-1:0]           u_ext   [NUM_CH];
    logic [ACC_W-1:0]           acc_sum [NUM_CH];
    logic [LOG2_SUM-1:0]        cnt;
    logic                       s_vld;
    logic [NUM_CH*OUT_W-1:0]    scaled;

    logic cnt_last;
    logic stall;
    logic advance;
    logic load_sum;
    logic scale_fire;

    assign cnt_last   = (cnt == CNT_LAST);
    // A finished sum can only land in sum_r if sum_r itself can move to the output this edge
    assign stall      = s_vld & out_valid & ~out_ready & cnt_last;
    assign advance    = enable & ~stall & ~seed_load;
    assign load_sum   = advance & cnt_last;
    assign scale_fire = s_vld & (~out_valid | out_ready);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic signed [CEN_W-1:0] centered;
        logic signed [PRD_W-1:0] cen_x;
        logic signed [PRD_W-1:0] gain_x;
        logic signed [PRD_W-1:0] prod;
        logic signed [PRD_W-1:0] shifted;

        assign u_ext[c]   = {{LOG2_SUM{1'b0}}, lfsr[c][31 -: OUT_W]};
        assign acc_sum[c] = acc[c] + u_ext[c];

        assign centered = $signed({1'b0, sum_r[c]}) - MEAN;
        assign cen_x    = {{(PRD_W-CEN_W){centered[CEN_W-1]}}, centered};
        assign gain_x   = {{(PRD_W-8){1'b0}}, gain};
        assign prod     = cen_x * gain_x;
        assign shifted  = prod >>> 4;

        assign scaled[c*OUT_W +: OUT_W] = (shifted > SAT_MAX) ? SAT_MAX[OUT_W-1:0] :
                                          (shifted < SAT_MIN) ? SAT_MIN[OUT_W-1:0] :
                                                                shifted[OUT_W-1:0];
    end

    // Uniform generation and accumulation: LFSRs, partial sums and the shared sample counter
    always_ff @(posedge CLK_100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                lfsr[c] <= chan_seed(SEED, c);
                acc[c]  <= '0;
            end
            cnt <= '0;
        end else if (seed_load) begin
            for (int c = 0; c < NUM_CH; c++) begin
                lfsr[c] <= chan_seed(seed, c);
                acc[c]  <= '0;
            end
            cnt <= '0;
        end else if (advance) begin
            for (int c = 0; c < NUM_CH; c++) begin
                lfsr[c] <= lfsr_next(lfsr[c]);
                acc[c]  <= (cnt == '0) ? u_ext[c] : acc_sum[c];
            end
            cnt <= cnt + 1'b1;
        end
    end

    // Finished-sum register and scaled output register with valid/ready handshake
    always_ff @(posedge CLK_100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                sum_r[c] <= '0;
            end
            s_vld     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (seed_load) begin
            s_vld     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (load_sum) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    sum_r[c] <= acc_sum[c];
                end
            end
            if (load_sum) begin
                s_vld <= 1'b1;
            end else if (scale_fire) begin
                s_vld <= 1'b0;
            end
            if (scale_fire) begin
                out_data  <= scaled;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
